// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable-rate SCLK bursts for any CPOL/CPHA with a start/busy/done handshake.
// Optional macro SPI_SCLK_CS_EN adds an active-low chip-select output cs_n.
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             master_slave,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] nbits,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic [CNT_W-1:0] bit_idx,
`ifdef SPI_SCLK_CS_EN
    output logic             cs_n,
`endif
    inout  wire              sclk
);

    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    state_t           state;
    logic             sclk_q;
    logic             cpol_q;
    logic             cpha_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] half_cnt;
    logic [CNT_W-1:0] nbits_q;
    // One extra bit so 2*nbits edges never overflow.
    logic [CNT_W:0]   edge_cnt;
    logic [CNT_W:0]   edge_nxt;
    logic             leading;

    assign edge_nxt = edge_cnt + 1'b1;
    assign leading  = edge_nxt[0];
    assign sclk     = master_slave ? sclk_q : 1'bz;

`ifdef SPI_SCLK_CS_EN
    // Chip select spans exactly the busy window, so lead and lag both equal one half period.
    assign cs_n = ~busy;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sclk_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            half_cnt   <= '0;
            nbits_q    <= '0;
            edge_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            bit_idx    <= '0;
        end else begin
            done       <= 1'b0;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_q <= cpol;
                    if (start && master_slave && (nbits != '0)) begin
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        div_q    <= div;
                        nbits_q  <= nbits;
                        half_cnt <= div;
                        edge_cnt <= '0;
                        bit_idx  <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!master_slave) begin
                        sclk_q <= cpol_q;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (half_cnt == '0) begin
                        half_cnt   <= div_q;
                        sclk_q     <= ~sclk_q;
                        edge_cnt   <= edge_nxt;
                        sample_stb <= leading ^ cpha_q;
                        shift_stb  <= ~(leading ^ cpha_q);
                        if (!leading) begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                        if (edge_nxt == {nbits_q, 1'b0}) begin
                            state <= TAIL;
                        end
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                TAIL: begin
                    sclk_q <= cpol_q;
                    if (!master_slave) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (half_cnt == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
